dlyline_code_ctrl: RTL and testbench

- Sequencer that drives the 64-bit thermometer control bus `bk[63:0]` of the 64-cell delay line.
- Accepts an absolute target code through a valid/ready handshake, or single-step inc/dec pulses from a DLL phase detector.
- Walks the line one cell at a time, waiting a programmable settle interval after each step, so the tap point never jumps more than one cell per update.
- Sits between the DLL/configuration logic and the delay-line macro. The `b63` pin is tied off outside this block.

---
 rtl/dlyline_code_ctrl.sv | 124 ++++++++++++
 tb/tb_dlyline_code_ctrl.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/dlyline_code_ctrl.sv
// Thermometer-code sequencer for the delay-line bk bus: walks one cell per step
// toward an absolute target or a single inc/dec, holding a settle interval after each step.
module dlyline_code_ctrl #(
    parameter int unsigned NCELL      = 64,
    parameter int unsigned SETTLE_CYC = 4,
    parameter int unsigned RST_CODE   = 0,
    localparam int unsigned CW        = $clog2(NCELL)
) (
    input  logic             clk,
    input  logic             rstb,
    input  logic             req_vld,
    input  logic [CW-1:0]    req_code,
    output logic             req_rdy,
    input  logic             inc,
    input  logic             dec,
    output logic [NCELL-1:0] bk,
    output logic [CW-1:0]    code,
    output logic             busy,
    output logic             done,
    output logic             sat
);

    localparam int unsigned   SW       = 8;
    localparam logic [CW-1:0] MAX_CODE = CW'(NCELL - 1);
    localparam logic [CW-1:0] RST_VAL  = CW'(RST_CODE);
    localparam logic [NCELL-1:0] ONES  = '1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STEP   = 2'd1,
        SETTLE = 2'd2
    } state_t;

    state_t         state, state_nxt;
    logic [CW-1:0]  target, target_nxt;
    logic [CW-1:0]  code_nxt;
    logic [SW-1:0]  cnt, cnt_nxt;
    logic [NCELL-1:0] bk_nxt;
    logic           done_nxt, sat_nxt;

    // State and registered outputs; bk is decoded from the next code so it never glitches
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            state   <= IDLE;
            code    <= RST_VAL;
            target  <= RST_VAL;
            cnt     <= '0;
            bk      <= ~(ONES << RST_VAL);
            req_rdy <= 1'b1;
            busy    <= 1'b0;
            done    <= 1'b0;
            sat     <= 1'b0;
        end else begin
            state   <= state_nxt;
            code    <= code_nxt;
            target  <= target_nxt;
            cnt     <= cnt_nxt;
            bk      <= bk_nxt;
            req_rdy <= (state_nxt == IDLE);
            busy    <= (state_nxt != IDLE);
            done    <= done_nxt;
            sat     <= sat_nxt;
        end
    end

    // Next-state, next-code and completion pulses
    always_comb begin
        state_nxt  = state;
        code_nxt   = code;
        target_nxt = target;
        cnt_nxt    = cnt;
        done_nxt   = 1'b0;
        sat_nxt    = 1'b0;

        case (state)
            IDLE: begin
                if (req_vld) begin
                    target_nxt = req_code;
                    if (req_code != code) begin
                        state_nxt = STEP;
                    end else begin
                        done_nxt = 1'b1;
                    end
                end else if (inc && !dec) begin
                    if (code != MAX_CODE) begin
                        target_nxt = code + CW'(1);
                        state_nxt  = STEP;
                    end else begin
                        sat_nxt  = 1'b1;
                        done_nxt = 1'b1;
                    end
                end else if (dec && !inc) begin
                    if (code != '0) begin
                        target_nxt = code - CW'(1);
                        state_nxt  = STEP;
                    end else begin
                        sat_nxt  = 1'b1;
                        done_nxt = 1'b1;
                    end
                end
            end
            STEP: begin
                code_nxt  = (target > code) ? code + CW'(1) : code - CW'(1);
                cnt_nxt   = SW'(SETTLE_CYC);
                state_nxt = SETTLE;
            end
            SETTLE: begin
                cnt_nxt = cnt - SW'(1);
                if (cnt == SW'(1)) begin
                    if (code == target) begin
                        state_nxt = IDLE;
                        done_nxt  = 1'b1;
                    end else begin
                        state_nxt = STEP;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase

        bk_nxt = ~(ONES << code_nxt);
    end

endmodule

// File: tb/tb_dlyline_code_ctrl.sv
// Directed bench for dlyline_code_ctrl: per-cycle walk timing checks plus a
// done/sat scoreboard and a bk thermometer/one-bit-step monitor.
module tb_dlyline_code_ctrl;

    localparam int unsigned S = 4;

    logic        clk;
    logic        rstb;
    logic        req_vld;
    logic [5:0]  req_code;
    logic        req_rdy;
    logic        inc;
    logic        dec;
    logic [63:0] bk;
    logic [5:0]  code;
    logic        busy;
    logic        done;
    logic        sat;

    typedef struct {
        logic [5:0] code;
        logic       sat;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    logic [63:0] prev_bk;

    dlyline_code_ctrl #(
        .NCELL(64),
        .SETTLE_CYC(S),
        .RST_CODE(0)
    ) dut (
        .clk(clk),
        .rstb(rstb),
        .req_vld(req_vld),
        .req_code(req_code),
        .req_rdy(req_rdy),
        .inc(inc),
        .dec(dec),
        .bk(bk),
        .code(code),
        .busy(busy),
        .done(done),
        .sat(sat)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        n_checks++;
        assert (obs === exp_v) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    function automatic logic [63:0] therm(input logic [5:0] c);
        logic [63:0] t;
        for (int i = 0; i < 64; i++) t[i] = (i < int'(c));
        return t;
    endfunction

    // Scoreboard and bk monitor, sampled on the falling edge
    always @(negedge clk) begin
        if (rstb) begin
            chk("bk_therm", bk, therm(code));
            if (bk !== prev_bk) chk("bk_onebit", 64'($countones(bk ^ prev_bk)), 64'd1);
            if (done) begin
                if (sb.size() == 0) begin
                    chk("done_unexpected", 64'(done), 64'd0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("sb_code", 64'(code), 64'(e.code));
                    chk("sb_sat", 64'(sat), 64'(e.sat));
                end
            end else if (sat) begin
                chk("sat_without_done", 64'(sat), 64'd0);
            end
        end
        prev_bk = bk;
    end

    task automatic start_req(input int c);
        @(negedge clk);
        req_vld  = 1'b1;
        req_code = 6'(c);
        sb.push_back('{6'(c), 1'b0});
        @(posedge clk);
        #1;
        req_vld = 1'b0;
    endtask

    task automatic pulse(input logic i_v, input logic d_v);
        @(negedge clk);
        inc = i_v;
        dec = d_v;
        @(posedge clk);
        #1;
        inc = 1'b0;
        dec = 1'b0;
    endtask

    // Checks every cycle after accept edge E0 through the done cycle
    task automatic check_walk(input int start, input int tgt);
        int n, per, steps, exp_code;
        n   = (tgt > start) ? tgt - start : start - tgt;
        per = int'(S) + 1;
        for (int j = 1; j <= n * per; j++) begin
            @(posedge clk);
            #1;
            steps = ((j - 1) / per) + 1;
            if (steps > n) steps = n;
            exp_code = (tgt > start) ? start + steps : start - steps;
            chk("walk_code", 64'(code), 64'(exp_code));
            chk("walk_rdy", 64'(req_rdy), 64'(j == n * per));
            chk("walk_busy", 64'(busy), 64'(j != n * per));
            chk("walk_done", 64'(done), 64'(j == n * per));
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, n_checks=%0d", n_checks);
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        rstb     = 1'b0;
        req_vld  = 1'b0;
        req_code = '0;
        inc      = 1'b0;
        dec      = 1'b0;
        #12;
        chk("rst_code", 64'(code), 64'd0);
        chk("rst_bk", bk, 64'd0);
        chk("rst_rdy", 64'(req_rdy), 64'd1);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_sat", 64'(sat), 64'd0);
        @(negedge clk);
        rstb = 1'b1;

        // 0 -> 3
        start_req(3);
        chk("e0_rdy_low", 64'(req_rdy), 64'd0);
        check_walk(0, 3);
        chk("bk_at_3", bk, 64'h7);

        // Same-code request completes immediately
        start_req(3);
        chk("eq_done", 64'(done), 64'd1);
        chk("eq_busy", 64'(busy), 64'd0);
        chk("eq_rdy", 64'(req_rdy), 64'd1);
        chk("eq_bk", bk, 64'h7);

        // 3 -> 10, then inc=dec=1 is a no-op
        start_req(10);
        check_walk(3, 10);
        pulse(1'b1, 1'b1);
        chk("noop_done", 64'(done), 64'd0);
        chk("noop_sat", 64'(sat), 64'd0);
        chk("noop_busy", 64'(busy), 64'd0);
        @(posedge clk);
        #1;
        chk("noop_code", 64'(code), 64'd10);
        chk("noop_done2", 64'(done), 64'd0);

        // 10 -> 0, then dec at 0 saturates
        start_req(0);
        check_walk(10, 0);
        sb.push_back('{6'd0, 1'b1});
        pulse(1'b0, 1'b1);
        chk("dec0_sat", 64'(sat), 64'd1);
        chk("dec0_done", 64'(done), 64'd1);
        chk("dec0_code", 64'(code), 64'd0);
        chk("dec0_busy", 64'(busy), 64'd0);

        // req beats inc; a held request is taken at the first ready cycle
        @(negedge clk);
        req_vld  = 1'b1;
        req_code = 6'd5;
        inc      = 1'b1;
        sb.push_back('{6'd5, 1'b0});
        @(posedge clk);
        #1;
        inc      = 1'b0;
        req_code = 6'd7;
        sb.push_back('{6'd7, 1'b0});
        check_walk(0, 5);
        @(posedge clk);
        #1;
        req_vld = 1'b0;
        chk("held_accept_code", 64'(code), 64'd5);
        chk("held_accept_busy", 64'(busy), 64'd1);
        check_walk(5, 7);

        // Single steps
        sb.push_back('{6'd8, 1'b0});
        pulse(1'b1, 1'b0);
        check_walk(7, 8);
        sb.push_back('{6'd7, 1'b0});
        pulse(1'b0, 1'b1);
        check_walk(8, 7);

        // Full-range walks and saturation at the top
        start_req(0);
        check_walk(7, 0);
        start_req(63);
        check_walk(0, 63);
        chk("bk_full", bk, 64'h7FFF_FFFF_FFFF_FFFF);
        sb.push_back('{6'd63, 1'b1});
        pulse(1'b1, 1'b0);
        chk("inc63_sat", 64'(sat), 64'd1);
        chk("inc63_done", 64'(done), 64'd1);
        chk("inc63_code", 64'(code), 64'd63);
        start_req(0);
        check_walk(63, 0);

        // Reset mid-walk toward 40
        start_req(40);
        k = 0;
        while (code != 6'd20 && k < 400) begin
            @(posedge clk);
            #1;
            k++;
        end
        chk("reach_20", 64'(code), 64'd20);
        #2;
        rstb = 1'b0;
        #1;
        sb.delete();
        chk("abort_code", 64'(code), 64'd0);
        chk("abort_bk", bk, 64'd0);
        chk("abort_rdy", 64'(req_rdy), 64'd1);
        chk("abort_busy", 64'(busy), 64'd0);
        chk("abort_done", 64'(done), 64'd0);
        repeat (3) @(posedge clk);
        #1;
        chk("abort_hold_code", 64'(code), 64'd0);
        chk("abort_hold_done", 64'(done), 64'd0);
        @(negedge clk);
        rstb = 1'b1;
        start_req(2);
        check_walk(0, 2);
        @(posedge clk);
        #1;
        chk("sb_empty", 64'(sb.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
